sys_cmd_ctrl: RTL and testbench

//  Command controller directly downstream of the UART receiver and upstream of the TX FIFO.

---
 rtl/sys_cmd_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// Command controller between the UART receiver and the TX FIFO: parses byte frames
// into register-file writes/reads and ALU operations, and pushes results to the FIFO.
module sys_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4,
    parameter int unsigned OPA_ADDR   = 0,
    parameter int unsigned OPB_ADDR   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_VALID,
    input  logic                    RX_ERR,
    output logic                    WR_EN,
    output logic                    RD_EN,
    output logic [ADDR_WIDTH-1:0]   ADDR,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic [DATA_WIDTH-1:0]   RD_DATA,
    input  logic                    RD_VALID,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_CLK_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_VALID,
    input  logic                    FIFO_FULL,
    output logic                    FIFO_WR,
    output logic [DATA_WIDTH-1:0]   FIFO_DATA,
    output logic                    BUSY
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OPA,
        S_OPB,
        S_FUN,
        S_ALU_WAIT,
        S_PUSH_RD,
        S_PUSH_LO,
        S_PUSH_HI
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   rd_byte_q, rd_byte_d;
    logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic                    clk_en_q, clk_en_d;

    logic rx_ok;
    logic rx_bad;

    assign rx_ok  = RX_VALID && !RX_ERR;
    assign rx_bad = RX_VALID && RX_ERR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_byte_q <= '0;
            alu_res_q <= '0;
            alu_fun_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_byte_q <= rd_byte_d;
            alu_res_q <= alu_res_d;
            alu_fun_q <= alu_fun_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            clk_en_q  <= clk_en_d;
        end
    end

    // Strobes are registered, so each one fires in the cycle after the byte that triggers it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rd_byte_d = rd_byte_q;
        alu_res_d = alu_res_q;
        alu_fun_d = alu_fun_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        clk_en_d  = clk_en_q;

        case (state_q)
            S_IDLE: begin
                if (rx_ok) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_d = S_WR_ADDR;
                        CMD_RD:     state_d = S_RD_ADDR;
                        CMD_ALU_OP: state_d = S_OPA;
                        CMD_ALU:    state_d = S_FUN;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (RD_VALID) begin
                    rd_byte_d = RD_DATA;
                    state_d   = S_PUSH_RD;
                end
            end
            S_OPA: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_OPB;
                end
            end
            S_OPB: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_FUN;
                end
            end
            S_FUN: begin
                if (rx_bad) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                // Gate stays open through the cycle ALU_VALID is seen, closes after it.
                if (ALU_VALID) begin
                    alu_res_d = ALU_OUT;
                    clk_en_d  = 1'b0;
                    state_d   = S_PUSH_LO;
                end
            end
            S_PUSH_RD: begin
                if (!FIFO_FULL) state_d = S_IDLE;
            end
            S_PUSH_LO: begin
                if (!FIFO_FULL) state_d = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                if (!FIFO_FULL) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        FIFO_DATA = '0;
        case (state_q)
            S_PUSH_RD: FIFO_DATA = rd_byte_q;
            S_PUSH_LO: FIFO_DATA = alu_res_q[DATA_WIDTH-1:0];
            S_PUSH_HI: FIFO_DATA = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
            default:   FIFO_DATA = '0;
        endcase
    end

    assign FIFO_WR    = !FIFO_FULL &&
                        (state_q == S_PUSH_RD || state_q == S_PUSH_LO || state_q == S_PUSH_HI);
    assign WR_EN      = wr_en_q;
    assign RD_EN      = rd_en_q;
    assign ALU_EN     = alu_en_q;
    assign ALU_CLK_EN = clk_en_q;
    assign ADDR       = addr_q;
    assign WR_DATA    = wr_data_q;
    assign ALU_FUN    = alu_fun_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: expected strobes are queued as frames are sent
// and matched against every WR_EN/RD_EN/ALU_EN/FIFO_WR the controller produces.
module tb_sys_cmd_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_p_data;
    logic        rx_valid;
    logic        rx_err;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        alu_clk_en;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  rd_resp   = 8'h00;
    logic [15:0] alu_resp  = 16'h0000;
    int          alu_delay = 2;

    localparam logic [3:0] K_WR = 4'd1, K_RD = 4'd2, K_ALU = 4'd3, K_FIFO = 4'd4;

    sys_cmd_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .FUN_WIDTH (4),
        .OPA_ADDR  (0),
        .OPB_ADDR  (1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_P_DATA (rx_p_data),
        .RX_VALID  (rx_valid),
        .RX_ERR    (rx_err),
        .WR_EN     (wr_en),
        .RD_EN     (rd_en),
        .ADDR      (addr),
        .WR_DATA   (wr_data),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .ALU_EN    (alu_en),
        .ALU_FUN   (alu_fun),
        .ALU_CLK_EN(alu_clk_en),
        .ALU_OUT   (alu_out),
        .ALU_VALID (alu_valid),
        .FIFO_FULL (fifo_full),
        .FIFO_WR   (fifo_wr),
        .FIFO_DATA (fifo_data),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] kind, input logic [3:0] a,
                                       input logic [15:0] d);
        return {kind, 4'h0, a, 4'h0, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic match(input string tag, input logic [31:0] act);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, act, 32'hFFFF_FFFF);
        else                   check(tag, act, exp_q.pop_front());
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(posedge clk); #1;
        rx_p_data = b;
        rx_valid  = 1'b1;
        rx_err    = err;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if ((32'(wr_en) + 32'(rd_en) + 32'(alu_en) + 32'(fifo_wr)) > 32'd1)
                check("strobe_exclusive",
                      32'(wr_en) + 32'(rd_en) + 32'(alu_en) + 32'(fifo_wr), 32'd1);
            if (wr_en)   match("wr",   mk(K_WR, addr, {8'h00, wr_data}));
            if (rd_en)   match("rd",   mk(K_RD, addr, 16'h0000));
            if (alu_en) begin
                match("alu", mk(K_ALU, 4'h0, {12'h000, alu_fun}));
                check("clk_en_at_alu_en", 32'(alu_clk_en), 32'd1);
            end
            if (fifo_wr) match("fifo", mk(K_FIFO, 4'h0, {8'h00, fifo_data}));
            if (alu_valid && busy) check("clk_en_at_valid", 32'(alu_clk_en), 32'd1);
        end
    endtask

    task automatic rd_responder();
        forever begin
            @(negedge clk);
            if (rd_en) begin
                @(posedge clk);
                @(posedge clk); #1;
                rd_data  = rd_resp;
                rd_valid = 1'b1;
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end
        end
    endtask

    task automatic alu_responder();
        forever begin
            @(negedge clk);
            if (alu_en) begin
                repeat (alu_delay) @(posedge clk);
                #1;
                alu_out   = alu_resp;
                alu_valid = 1'b1;
                @(posedge clk); #1;
                alu_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_p_data = 8'h00;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        rd_data   = 8'h00;
        rd_valid  = 1'b0;
        alu_out   = 16'h0000;
        alu_valid = 1'b0;
        fifo_full = 1'b0;

        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_addr",    32'(addr),       32'd0);
        check("rst_wr_data", 32'(wr_data),    32'd0);
        check("rst_clk_en",  32'(alu_clk_en), 32'd0);
        check("rst_strobes", 32'({wr_en, rd_en, alu_en, fifo_wr}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fork
            monitor();
            rd_responder();
            alu_responder();
        join_none

        // Register write
        exp_q.push_back(mk(K_WR, 4'h5, 16'h003C));
        send_byte(8'hAA, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h3C, 1'b0);
        wait_done("write");
        check("write_busy_after", 32'(busy), 32'd0);

        // Register read
        rd_resp = 8'h3C;
        exp_q.push_back(mk(K_RD, 4'h5, 16'h0000));
        exp_q.push_back(mk(K_FIFO, 4'h0, 16'h003C));
        send_byte(8'hBB, 1'b0);
        send_byte(8'h05, 1'b0);
        wait_done("read");

        // ALU with operands
        alu_resp  = 16'h000D;
        alu_delay = 2;
        exp_q.push_back(mk(K_WR, 4'h0, 16'h000A));
        exp_q.push_back(mk(K_WR, 4'h1, 16'h0003));
        exp_q.push_back(mk(K_ALU, 4'h0, 16'h0000));
        exp_q.push_back(mk(K_FIFO, 4'h0, 16'h000D));
        exp_q.push_back(mk(K_FIFO, 4'h0, 16'h0000));
        send_byte(8'hCC, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done("alu_op");
        check("alu_clk_en_closed", 32'(alu_clk_en), 32'd0);

        // Stored-operand ALU with FIFO full stalling the pushes
        fifo_full = 1'b1;
        alu_resp  = 16'h1234;
        exp_q.push_back(mk(K_ALU, 4'h0, 16'h0002));
        exp_q.push_back(mk(K_FIFO, 4'h0, 16'h0034));
        exp_q.push_back(mk(K_FIFO, 4'h0, 16'h0012));
        send_byte(8'hDD, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("full_hold_data", 32'(fifo_data), 32'h34);
        check("full_busy",      32'(busy),      32'd1);
        check("full_no_wr",     32'(fifo_wr),   32'd0);
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_done("alu_full");

        // Error byte aborts a write; trailing byte and stray byte ignored in IDLE
        send_byte(8'hAA, 1'b0);
        send_byte(8'h05, 1'b1);
        @(negedge clk);
        check("err_abort_busy", 32'(busy), 32'd0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        send_byte(8'hAA, 1'b1);
        @(negedge clk);
        check("idle_err_ignored", 32'(busy), 32'd0);
        wait_done("errors");

        // Write with upper address bits set only the low nibble reaches ADDR
        exp_q.push_back(mk(K_WR, 4'hA, 16'h0077));
        send_byte(8'hAA, 1'b0);
        send_byte(8'h3A, 1'b0);
        send_byte(8'h77, 1'b0);
        wait_done("write_trunc");

        // Reset during ALU_WAIT: nothing pushed even when ALU_VALID arrives later
        alu_delay = 20;
        alu_resp  = 16'hBEEF;
        exp_q.push_back(mk(K_WR, 4'h0, 16'h0011));
        exp_q.push_back(mk(K_WR, 4'h1, 16'h0022));
        exp_q.push_back(mk(K_ALU, 4'h0, 16'h0005));
        send_byte(8'hCC, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h25, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wait_busy",   32'(busy),       32'd1);
        check("wait_clk_en", 32'(alu_clk_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy",    32'(busy),       32'd0);
        check("midrst_clk_en",  32'(alu_clk_en), 32'd0);
        check("midrst_addr",    32'(addr),       32'd0);
        check("midrst_wr_data", 32'(wr_data),    32'd0);
        check("midrst_alu_fun", 32'(alu_fun),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        check("midrst_idle",        32'(busy),         32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
